// File: rtl/edusoc_data_initiator.sv
// Host-command to SoC data-bus initiator with bus timeout, plus an
// independent interrupt latch/acknowledge path toward the host.
module edusoc_data_initiator #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RES,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WE,
  input  logic [3:0]  CMD_BE,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        DATA_REQ,
  input  logic        DATA_VALID,
  output logic        DATA_WE,
  output logic [3:0]  DATA_BE,
  output logic [31:0] DATA_ADDR,
  output logic [31:0] DATA_WDATA,
  input  logic [31:0] DATA_RDATA,
  input  logic        IRQ,
  input  logic [4:0]  IRQ_ID,
  output logic        IRQ_ACK,
  output logic [4:0]  IRQ_ACK_ID,
  output logic        IRQ_PENDING,
  output logic [4:0]  IRQ_PENDING_ID,
  input  logic        IRQ_CLEAR
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [15:0] LAST_CNT = TIMEOUT_CYCLES - 16'd1;

  state_t      state_q;
  logic        cmd_ready_q;
  logic        data_req_q;
  logic        data_we_q;
  logic [3:0]  data_be_q;
  logic [31:0] data_addr_q;
  logic [31:0] data_wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        timeout_hit;

  logic        irq_pending_q, irq_pending_d;
  logic [4:0]  irq_pending_id_q, irq_pending_id_d;
  logic        irq_ack_q, irq_ack_d;
  logic [4:0]  irq_ack_id_q, irq_ack_id_d;

  assign cnt_d       = cnt_q + 16'd1;
  assign timeout_hit = (cnt_q == LAST_CNT);

  // cmd_ready_q stays low through reset and rises on the first edge after release
  always_ff @(posedge CPU_CLK or posedge CPU_RES) begin
    if (CPU_RES) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= 4'd0;
      data_addr_q  <= 32'd0;
      data_wdata_q <= 32'd0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'd0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && CMD_VALID) begin
            cmd_ready_q <= 1'b0;
            cnt_q       <= 16'd0;
            if (CMD_BE != 4'd0) begin
              state_q      <= BUS;
              data_req_q   <= 1'b1;
              data_we_q    <= CMD_WE;
              data_be_q    <= CMD_BE;
              data_addr_q  <= CMD_ADDR;
              data_wdata_q <= CMD_WDATA;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= 32'd0;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        BUS: begin
          cnt_q <= cnt_d;
          // a completion arriving on the timeout cycle still counts as success
          if (DATA_VALID || timeout_hit) begin
            state_q      <= RESP;
            data_req_q   <= 1'b0;
            data_we_q    <= 1'b0;
            data_be_q    <= 4'd0;
            data_addr_q  <= 32'd0;
            data_wdata_q <= 32'd0;
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= ~DATA_VALID;
            rsp_rdata_q  <= (DATA_VALID && !data_we_q) ? DATA_RDATA : 32'd0;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // IRQ is not re-sampled during the acknowledge pulse cycle
  always_comb begin
    irq_ack_d        = irq_pending_q & IRQ_CLEAR;
    irq_ack_id_d     = irq_ack_d ? irq_pending_id_q : 5'd0;
    irq_pending_d    = irq_pending_q;
    irq_pending_id_d = irq_pending_id_q;
    if (irq_ack_d) begin
      irq_pending_d    = 1'b0;
      irq_pending_id_d = 5'd0;
    end else if (!irq_pending_q && !irq_ack_q && IRQ) begin
      irq_pending_d    = 1'b1;
      irq_pending_id_d = IRQ_ID;
    end
  end

  always_ff @(posedge CPU_CLK or posedge CPU_RES) begin
    if (CPU_RES) begin
      irq_pending_q    <= 1'b0;
      irq_pending_id_q <= 5'd0;
      irq_ack_q        <= 1'b0;
      irq_ack_id_q     <= 5'd0;
    end else begin
      irq_pending_q    <= irq_pending_d;
      irq_pending_id_q <= irq_pending_id_d;
      irq_ack_q        <= irq_ack_d;
      irq_ack_id_q     <= irq_ack_id_d;
    end
  end

  assign CMD_READY      = cmd_ready_q;
  assign DATA_REQ       = data_req_q;
  assign DATA_WE        = data_we_q;
  assign DATA_BE        = data_be_q;
  assign DATA_ADDR      = data_addr_q;
  assign DATA_WDATA     = data_wdata_q;
  assign RSP_VALID      = rsp_valid_q;
  assign RSP_RDATA      = rsp_rdata_q;
  assign RSP_ERR        = rsp_err_q;
  assign IRQ_ACK        = irq_ack_q;
  assign IRQ_ACK_ID     = irq_ack_id_q;
  assign IRQ_PENDING    = irq_pending_q;
  assign IRQ_PENDING_ID = irq_pending_id_q;

endmodule

// File: tb/tb_edusoc_data_initiator.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_edusoc_data_initiator;

  localparam int TO = 4;
  localparam int P_IDLE = 0;
  localparam int P_BUS  = 1;
  localparam int P_RESP = 2;

  logic        CPU_CLK;
  logic        CPU_RES;
  logic        CMD_VALID, CMD_READY, CMD_WE;
  logic [3:0]  CMD_BE;
  logic [31:0] CMD_ADDR, CMD_WDATA;
  logic        RSP_VALID, RSP_READY, RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic        DATA_REQ, DATA_VALID, DATA_WE;
  logic [3:0]  DATA_BE;
  logic [31:0] DATA_ADDR, DATA_WDATA, DATA_RDATA;
  logic        IRQ, IRQ_ACK, IRQ_PENDING, IRQ_CLEAR;
  logic [4:0]  IRQ_ID, IRQ_ACK_ID, IRQ_PENDING_ID;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  edusoc_data_initiator #(.TIMEOUT_CYCLES(16'd4)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RES(CPU_RES),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WE(CMD_WE),
    .CMD_BE(CMD_BE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .DATA_REQ(DATA_REQ), .DATA_VALID(DATA_VALID),
    .DATA_WE(DATA_WE), .DATA_BE(DATA_BE), .DATA_ADDR(DATA_ADDR),
    .DATA_WDATA(DATA_WDATA), .DATA_RDATA(DATA_RDATA), .IRQ(IRQ),
    .IRQ_ID(IRQ_ID), .IRQ_ACK(IRQ_ACK), .IRQ_ACK_ID(IRQ_ACK_ID),
    .IRQ_PENDING(IRQ_PENDING), .IRQ_PENDING_ID(IRQ_PENDING_ID),
    .IRQ_CLEAR(IRQ_CLEAR)
  );

  initial CPU_CLK = 1'b0;
  always #5 CPU_CLK = ~CPU_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction phase plus bus-cycle count for the current transfer
  int          m_ph;
  bit          m_started;
  int          m_busn;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_err;
  logic        m_pend, m_ack;
  logic [4:0]  m_pid, m_ackid;

  always @(posedge CPU_CLK or posedge CPU_RES) begin
    if (CPU_RES) begin
      m_ph <= P_IDLE; m_started <= 0; m_busn <= 0;
      m_we <= 0; m_be <= 0; m_addr <= 0; m_wdata <= 0; m_rdata <= 0; m_err <= 0;
      m_pend <= 0; m_ack <= 0; m_pid <= 0; m_ackid <= 0;
    end else begin
      m_started <= 1;
      m_ack     <= m_pend && IRQ_CLEAR;
      m_ackid   <= (m_pend && IRQ_CLEAR) ? m_pid : 5'd0;
      if (m_pend && IRQ_CLEAR) m_pend <= 0;
      else if (!m_pend && !m_ack && IRQ) begin
        m_pend <= 1;
        m_pid  <= IRQ_ID;
      end
      if (m_ph == P_IDLE) begin
        if (m_started && CMD_VALID) begin
          m_we <= CMD_WE; m_be <= CMD_BE; m_addr <= CMD_ADDR; m_wdata <= CMD_WDATA;
          if (CMD_BE == 4'd0) begin
            m_ph <= P_RESP; m_rdata <= 0; m_err <= 1;
          end else begin
            m_ph <= P_BUS; m_busn <= 1;
          end
        end
      end else if (m_ph == P_BUS) begin
        if (DATA_VALID) begin
          m_ph <= P_RESP; m_err <= 0;
          m_rdata <= m_we ? 32'd0 : DATA_RDATA;
        end else if (m_busn == TO) begin
          m_ph <= P_RESP; m_err <= 1; m_rdata <= 0;
        end else begin
          m_busn <= m_busn + 1;
        end
      end else begin
        if (RSP_READY) m_ph <= P_IDLE;
      end
    end
  end

  always @(negedge CPU_CLK) begin
    if (chk_en && !CPU_RES) begin
      chk("cmd_ready", 32'(CMD_READY), 32'(m_ph == P_IDLE && m_started));
      chk("data_req", 32'(DATA_REQ), 32'(m_ph == P_BUS));
      if (m_ph == P_BUS) begin
        chk("data_we_be", {27'd0, DATA_WE, DATA_BE}, {27'd0, m_we, m_be});
        chk("data_addr", DATA_ADDR, m_addr);
        chk("data_wdata", DATA_WDATA, m_wdata);
      end else if (m_ph == P_IDLE) begin
        chk("idle_we_be", {27'd0, DATA_WE, DATA_BE}, 32'd0);
        chk("idle_addr", DATA_ADDR, 32'd0);
        chk("idle_wdata", DATA_WDATA, 32'd0);
      end
      chk("rsp_valid", 32'(RSP_VALID), 32'(m_ph == P_RESP));
      if (m_ph == P_RESP) begin
        chk("rsp_rdata", RSP_RDATA, m_rdata);
        chk("rsp_err", 32'(RSP_ERR), 32'(m_err));
      end
      chk("irq_pending", 32'(IRQ_PENDING), 32'(m_pend));
      if (m_pend) chk("irq_pending_id", 32'(IRQ_PENDING_ID), 32'(m_pid));
      chk("irq_ack", 32'(IRQ_ACK), 32'(m_ack));
      chk("irq_ack_id", 32'(IRQ_ACK_ID), 32'(m_ackid));
    end
  end

  task automatic tick();
    @(negedge CPU_CLK);
  endtask

  task automatic quiet();
    CMD_VALID = 0; CMD_WE = 0; CMD_BE = 0; CMD_ADDR = 0; CMD_WDATA = 0;
    RSP_READY = 0; DATA_VALID = 0; DATA_RDATA = 0;
    IRQ = 0; IRQ_ID = 0; IRQ_CLEAR = 0;
  endtask

  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata);
    CMD_VALID = 1; CMD_WE = we; CMD_BE = be; CMD_ADDR = addr; CMD_WDATA = wdata;
  endtask

  // called mid-cycle; returns mid-cycle one edge after reset release
  task automatic do_reset();
    #2 CPU_RES = 1;
    #1;
    chk("rst_ctrl", {25'd0, CMD_READY, DATA_REQ, DATA_WE, RSP_VALID, RSP_ERR, IRQ_ACK, IRQ_PENDING}, 32'd0);
    chk("rst_be_ids", {18'd0, DATA_BE, IRQ_ACK_ID, IRQ_PENDING_ID}, 32'd0);
    chk("rst_addr", DATA_ADDR, 32'd0);
    chk("rst_wdata", DATA_WDATA, 32'd0);
    chk("rst_rdata", RSP_RDATA, 32'd0);
    @(negedge CPU_CLK);
    chk("rst_hold_ready", 32'(CMD_READY), 32'd0);
    @(negedge CPU_CLK);
    #2 CPU_RES = 0;
    @(negedge CPU_CLK);
    chk("rst_release_ready", 32'(CMD_READY), 32'd1);
    chk("rst_release_rsp", 32'(RSP_VALID), 32'd0);
  endtask

  initial begin
    int n;
    int acks;
    CPU_RES = 0;
    quiet();
    @(negedge CPU_CLK);
    do_reset();
    chk_en = 1;

    // Read with completion on the third bus cycle
    issue(0, 4'hF, 32'h10, 32'h0);
    n = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      CMD_VALID = 0;
      if (DATA_REQ) n++;
      DATA_VALID = (c == 3);
      DATA_RDATA = (c == 3) ? 32'hDEADBEEF : 32'h0;
      if (c == 4) begin
        chk("rd_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("rd_rsp_rdata", RSP_RDATA, 32'hDEADBEEF);
        chk("rd_rsp_err", 32'(RSP_ERR), 32'd0);
        RSP_READY = 1;
      end
      if (c == 5) begin
        chk("rd_back_idle", 32'(CMD_READY), 32'd1);
        RSP_READY = 0;
      end
    end
    chk("rd_req_cycles", n, 32'd3);

    // Write with response held off for three cycles
    issue(1, 4'h3, 32'h20, 32'h12345678);
    for (int c = 1; c <= 7; c++) begin
      tick();
      CMD_VALID = 0;
      if (c <= 2) begin
        chk("wr_req", 32'(DATA_REQ), 32'd1);
        chk("wr_fields", {DATA_WE, 3'd0, DATA_BE, 24'd0}, {1'b1, 3'd0, 4'h3, 24'd0});
        chk("wr_addr", DATA_ADDR, 32'h20);
        chk("wr_wdata", DATA_WDATA, 32'h12345678);
      end
      DATA_VALID = (c == 2);
      DATA_RDATA = 32'hFFFFFFFF;
      if (c >= 3 && c <= 6) begin
        chk("wr_rsp_held", {31'd0, RSP_VALID}, 32'd1);
        chk("wr_rsp_rdata", RSP_RDATA, 32'd0);
        chk("wr_rsp_err", 32'(RSP_ERR), 32'd0);
      end
      RSP_READY = (c == 6);
    end
    RSP_READY = 0;

    // Timeout: no completion at all
    issue(0, 4'hF, 32'h40, 32'h0);
    n = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      CMD_VALID = 0;
      if (DATA_REQ) n++;
      if (c == 5) begin
        chk("to_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("to_rsp_err", 32'(RSP_ERR), 32'd1);
        chk("to_rsp_rdata", RSP_RDATA, 32'd0);
      end
      RSP_READY = (c == 7);
    end
    chk("to_req_cycles", n, 32'd4);
    tick();
    RSP_READY = 0;

    // Completion on the last allowed cycle wins over timeout
    issue(0, 4'hF, 32'h44, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      CMD_VALID = 0;
      DATA_VALID = (c == 4);
      DATA_RDATA = 32'h0BADF00D;
      if (c == 5) begin
        chk("to_edge_err", 32'(RSP_ERR), 32'd0);
        chk("to_edge_rdata", RSP_RDATA, 32'h0BADF00D);
      end
      RSP_READY = (c == 5);
    end
    RSP_READY = 0;

    // Zero byte-enable
    issue(0, 4'h0, 32'h50, 32'h0);
    tick();
    CMD_VALID = 0;
    chk("be0_req", 32'(DATA_REQ), 32'd0);
    chk("be0_rsp", {30'd0, RSP_VALID, RSP_ERR}, 32'd3);
    chk("be0_rdata", RSP_RDATA, 32'd0);
    RSP_READY = 1;
    tick();
    RSP_READY = 0;

    // Interrupt acknowledged during an active read
    issue(0, 4'hF, 32'h80, 32'h0);
    IRQ = 1; IRQ_ID = 5'd5;
    tick();
    CMD_VALID = 0; IRQ = 0;
    chk("irq_pend", {26'd0, IRQ_PENDING, IRQ_PENDING_ID}, {26'd0, 1'b1, 5'd5});
    IRQ_CLEAR = 1;
    acks = 0;
    for (int c = 2; c <= 6; c++) begin
      tick();
      IRQ_CLEAR = 0;
      if (IRQ_ACK) begin
        acks++;
        chk("irq_ack_id_lit", 32'(IRQ_ACK_ID), 32'd5);
      end
      DATA_VALID = (c == 2);
      DATA_RDATA = 32'hA5A5A5A5;
      if (c == 3) chk("irq_rd_rdata", RSP_RDATA, 32'hA5A5A5A5);
      RSP_READY = (c == 4);
    end
    chk("irq_ack_count", acks, 32'd1);
    chk("irq_pend_cleared", 32'(IRQ_PENDING), 32'd0);
    RSP_READY = 0;

    // Reset mid-transfer with an interrupt pending
    issue(0, 4'hF, 32'h90, 32'h0);
    IRQ = 1; IRQ_ID = 5'd9;
    tick();
    CMD_VALID = 0; IRQ = 0;
    chk("mid_req", {30'd0, DATA_REQ, IRQ_PENDING}, 32'd3);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      CMD_VALID  = 1'($urandom_range(0, 1));
      CMD_WE     = 1'($urandom_range(0, 1));
      CMD_BE     = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      CMD_ADDR   = $urandom;
      CMD_WDATA  = $urandom;
      RSP_READY  = 1'($urandom_range(0, 1));
      DATA_VALID = ($urandom_range(0, 9) < 3);
      DATA_RDATA = $urandom;
      IRQ        = ($urandom_range(0, 3) == 0);
      IRQ_ID     = 5'($urandom_range(0, 31));
      IRQ_CLEAR  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
